exe_mem_skid_reg: RTL
=====================

# exe_mem_skid_reg

Parametrised EXE→MEM pipeline register with a valid/ready handshake and a two-entry skid buffer. It sits between the execute stage and the memory stage, and lets the memory stage stall for multi-cycle data-memory accesses without a combinational ready path back into execute. It also provides a synchronous flush and a saturating stall-cycle counter for performance monitoring.

## Interface
- DATA_W, 32, width of ALU result and Rm value
- DEST_W, 4, destination register index width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low)
- in_valid  in  1  execute stage presents a beat
- in_ready  out  1  register can accept a beat (registered)
- MEM_R_EN_in, MEM_W_EN_in, WB_EN_in  in  1 each  control bits
- Dest_in  in  DEST_W  destination register
- ALU_Res_in  in  DATA_W  ALU result / address
- Val_Rm_in  in  DATA_W  store data
- flush  in  1  synchronous kill of all held beats
- out_valid  out  1  beat available to memory stage
- out_ready  in  1  memory stage consumes beat
- MEM_R_EN_out, MEM_W_EN_out, WB_EN_out  out  1 each  control bits, gated by out_valid
- Dest_out  out  DEST_W
- ALU_Res_out  out  DATA_W
- Val_Rm_out  out  DATA_W
- stat_clr  in  1  synchronous clear of stall counter
- stall_cycles  out  CNT_W  saturating count of stalled cycles

## Operation
- Storage: main entry (drives outputs) and skid entry. Each entry holds a valid bit and a payload {ctrl[3], Dest, ALU_Res, Val_Rm}.
- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- in_ready = !skid_valid, registered. out_valid = main_valid.
- States and transitions:
  - EMPTY: accept → ONE, main ← in.
  - ONE:
    - accept and emit → ONE, main ← in.
    - accept without emit → TWO, skid ← in.
    - emit without accept → EMPTY.
    - neither → ONE, hold.
  - TWO: emit → ONE, main ← skid. No emit → hold. Accept cannot occur because in_ready = 0.
- flush has the highest priority. Next state is EMPTY and both valid bits are cleared. A beat offered in the flush cycle is dropped. Payload registers may retain stale data.
- Control outputs = stored bit AND out_valid. Memory and write-back enables are therefore never asserted for an empty or flushed entry.
- Dest/ALU_Res/Val_Rm outputs reflect the main payload. They are don't-care while out_valid = 0.
- Beats leave strictly in arrival order, with no loss or duplication except on flush.
- stall_cycles increments each cycle out_valid && !out_ready and saturates at 2^CNT_W−1.
  - stat_clr forces 0 and wins over a simultaneous increment.
  - flush does not affect the counter.

## Timing
- Reset (rst = 0, asynchronous): all valid bits 0, all payloads 0, all outputs 0 except in_ready = 1, stall_cycles = 0. Release is synchronous to clk.
- Latency: a beat accepted at edge N appears at the outputs after edge N (1 cycle) when the register is empty or draining.
- Throughput: 1 beat/cycle while out_ready = 1.
- Stall onset:
  - With main full and out_ready = 0, one more beat is accepted into skid.
  - in_ready falls after that edge.
  - The execute stage sees back-pressure one cycle later than the stall. No beat is lost.
- Stall release (TWO, out_ready = 1): the skid beat moves to main and in_ready rises after the same edge.
- Reset asserted mid-stall: contents are discarded immediately and outputs go to reset values asynchronously.

## Test plan
- Reset: drive rst = 0 with in_valid = 1 and payload 0xDEADBEEF → all outputs 0, in_ready = 1. After release and one accept cycle, ALU_Res_out = 0xDEADBEEF and out_valid = 1.
- Streaming: 8 beats with ALU_Res = 1..8, out_ready = 1 constantly → outputs 1..8 on consecutive cycles, in_ready stays 1, stall_cycles = 0.
- Stall/skid: send beats A = 0x10, B = 0x20, C = 0x30 back-to-back, out_ready = 0 from the cycle A appears.
  - B lands in skid, in_ready = 0, C is held off.
  - Release after 3 stall cycles → A, B, C emitted in order, stall_cycles = 3.
- Flush in TWO state with MEM_W_EN = 1 beats held → next cycle out_valid = 0, MEM_W_EN_out = 0, in_ready = 1. A beat offered during the flush cycle never appears.
- Counter saturation (CNT_W = 4): hold out_valid = 1, out_ready = 0 for 20 cycles → stall_cycles = 15. Assert stat_clr while still stalled → 0 next cycle, then 1.
- Control gating: accept a beat with WB_EN = 1, emit it, then idle → WB_EN_out = 0 while empty, even though the payload register still holds 1.

Source files
------------

// File: rtl/exe_mem_skid_reg.sv
// exe_mem_skid_reg
// EXE->MEM pipeline register with a valid/ready handshake and a two-entry
// skid buffer. The memory stage can stall for multi-cycle accesses without
// a combinational ready path reaching back into execute. in_ready comes
// straight from a flop. The block also has a synchronous flush and a
// saturating stall-cycle counter.
//
// Ports
//   clk          pipeline clock; all state changes on the rising edge
//   rst          asynchronous, active-low reset
//   in_valid     execute stage offers a beat
//   in_ready     register can take a beat (registered)
//   MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, Dest_in, ALU_Res_in, Val_Rm_in
//                incoming beat payload
//   flush        synchronous kill of every held beat (highest priority)
//   out_valid    a beat is presented to the memory stage
//   out_ready    memory stage consumes the presented beat
//   MEM_R_EN_out, MEM_W_EN_out, WB_EN_out
//                control bits, forced low while out_valid is low
//   Dest_out, ALU_Res_out, Val_Rm_out
//                main-entry payload (don't-care while out_valid is low)
//   stat_clr     synchronous clear of the stall counter
//   stall_cycles saturating count of cycles with out_valid && !out_ready
module exe_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic              WB_EN_in,
    input  logic [DEST_W-1:0] Dest_in,
    input  logic [DATA_W-1:0] ALU_Res_in,
    input  logic [DATA_W-1:0] Val_Rm_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              MEM_R_EN_out,
    output logic              MEM_W_EN_out,
    output logic              WB_EN_out,
    output logic [DEST_W-1:0] Dest_out,
    output logic [DATA_W-1:0] ALU_Res_out,
    output logic [DATA_W-1:0] Val_Rm_out,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int PAY_W = 3 + DEST_W + 2 * DATA_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               main_valid_reg, skid_valid_reg, in_ready_reg;
    logic               main_valid_next, skid_valid_next;
    logic [PAY_W-1:0]   main_pay_reg, skid_pay_reg;
    logic [PAY_W-1:0]   in_pay;
    logic               main_load_in, main_load_skid, skid_load;
    logic               accept, emit;
    logic [CNT_W-1:0]   stall_cnt_reg;
    logic [2:0]         ctrl_stored;
    logic [2:0]         ctrl_gated;

    assign in_pay = {MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, Dest_in, ALU_Res_in, Val_Rm_in};
    assign accept = in_valid && in_ready_reg;
    assign emit   = main_valid_reg && out_ready;

    // Next-state and entry-load decode
    always_comb begin
        state_next     = state_reg;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            // Everything held is dropped, including a beat offered this cycle.
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next   = ST_ONE;
                        main_load_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        main_load_in = 1'b1;
                    end else if (accept) begin
                        state_next = ST_TWO;
                        skid_load  = 1'b1;
                    end else if (emit) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only draining can happen.
                    if (emit) begin
                        state_next     = ST_ONE;
                        main_load_skid = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
        main_valid_next = (state_next != ST_EMPTY);
        skid_valid_next = (state_next == ST_TWO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_EMPTY;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
            main_pay_reg   <= '0;
            skid_pay_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            // Ready comes from a flop. It is computed from the next skid
            // occupancy, so it drops right after the beat that fills the skid.
            in_ready_reg   <= !skid_valid_next;
            if (main_load_in) begin
                main_pay_reg <= in_pay;
            end else if (main_load_skid) begin
                main_pay_reg <= skid_pay_reg;
            end
            if (skid_load) begin
                skid_pay_reg <= in_pay;
            end
        end
    end

    // Saturating stall counter; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
        end else if (stat_clr) begin
            stall_cnt_reg <= '0;
        end else if (main_valid_reg && !out_ready && !(&stall_cnt_reg)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
        end
    end

    assign {ctrl_stored, Dest_out, ALU_Res_out, Val_Rm_out} = main_pay_reg;

    // Stale control bits in an empty entry must never reach memory/write-back.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ctrl_gate
            assign ctrl_gated[gi] = ctrl_stored[gi] & main_valid_reg;
        end
    endgenerate

    assign MEM_R_EN_out = ctrl_gated[2];
    assign MEM_W_EN_out = ctrl_gated[1];
    assign WB_EN_out    = ctrl_gated[0];
    assign out_valid    = main_valid_reg;
    assign in_ready     = in_ready_reg;
    assign stall_cycles = stall_cnt_reg;

endmodule
